// File: rtl/tcam_pkg.sv
// Shared constants and types for the ternary CAM search block.
package tcam_pkg;

  localparam int TCAM_KEY_W = 10;
  localparam int TCAM_DEPTH = 16;

  typedef logic [TCAM_DEPTH-1:0] match_vec_t;

endpackage

// File: rtl/tcam_prio_enc.sv
// Two-deep priority encoder plus popcount over a match vector.
module tcam_prio_enc #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic [DEPTH-1:0] vec,
  output logic             hit0,
  output logic [AW-1:0]    addr0,
  output logic             hit1,
  output logic [AW-1:0]    addr1,
  output logic [CW-1:0]    count
);

  // Ascending scan: first set bit claims slot 0, second claims slot 1.
  always_comb begin
    hit0  = 1'b0;
    addr0 = '0;
    hit1  = 1'b0;
    addr1 = '0;
    count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vec[i]) begin
        count = count + CW'(1);
        if (!hit0) begin
          hit0  = 1'b1;
          addr0 = AW'(i);
        end else if (!hit1) begin
          hit1  = 1'b1;
          addr1 = AW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/tcam_prio.sv
// Ternary CAM with masked entries and a two-stage search pipe reporting the
// two lowest matching indices and the total match count.
module tcam_prio
  import tcam_pkg::*;
#(
  parameter int KEY_W = TCAM_KEY_W,
  parameter int DEPTH = TCAM_DEPTH,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [KEY_W-1:0] wr_key,
  input  logic [KEY_W-1:0] wr_mask,
  input  logic             wr_valid,
  input  logic             srch_valid,
  output logic             srch_ready,
  input  logic [KEY_W-1:0] srch_key,
  output logic             rslt_valid,
  input  logic             rslt_ready,
  output logic             rslt_hit0,
  output logic [AW-1:0]    rslt_addr0,
  output logic             rslt_hit1,
  output logic [AW-1:0]    rslt_addr1,
  output logic [CW-1:0]    rslt_count
);

  logic [KEY_W-1:0] key_q  [DEPTH];
  logic [KEY_W-1:0] mask_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] wr_sel;
  logic [DEPTH-1:0] match_vec;

  logic             advance;
  logic             accept;
  logic [1:0]       vld_pipe;   // [0] = stage 1, [1] = result register
  logic [DEPTH-1:0] s1_vec;

  logic             enc_hit0, enc_hit1;
  logic [AW-1:0]    enc_addr0, enc_addr1;
  logic [CW-1:0]    enc_count;

  // Decoding only indices below DEPTH drops out-of-range writes for free.
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    assign wr_sel[i]    = wr_en && (wr_addr == AW'(i));
    assign match_vec[i] = valid_q[i] &&
                          (((srch_key ^ key_q[i]) & ~mask_q[i]) == '0);
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_sel[i]) begin
        key_q[i]  <= wr_key;
        mask_q[i] <= wr_mask;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_sel[i]) valid_q[i] <= wr_valid;
      end
    end
  end

  assign advance    = !vld_pipe[1] || rslt_ready;
  assign srch_ready = advance;
  assign accept     = srch_valid && advance;
  assign rslt_valid = vld_pipe[1];

  tcam_prio_enc #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .CW    (CW)
  ) u_enc (
    .vec   (s1_vec),
    .hit0  (enc_hit0),
    .addr0 (enc_addr0),
    .hit1  (enc_hit1),
    .addr1 (enc_addr1),
    .count (enc_count)
  );

  // Whole pipe moves in lockstep; a stall freezes the captured match vector.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe   <= '0;
      s1_vec     <= '0;
      rslt_hit0  <= 1'b0;
      rslt_addr0 <= '0;
      rslt_hit1  <= 1'b0;
      rslt_addr1 <= '0;
      rslt_count <= '0;
    end else if (advance) begin
      vld_pipe   <= {vld_pipe[0], accept};
      s1_vec     <= accept ? match_vec : '0;
      rslt_hit0  <= enc_hit0;
      rslt_addr0 <= enc_addr0;
      rslt_hit1  <= enc_hit1;
      rslt_addr1 <= enc_addr1;
      rslt_count <= enc_count;
    end
  end

endmodule

// File: doc/tcam_prio.md
# tcam_prio

Parametrised ternary CAM with per-entry don't-care masks, entry valid bits and a two-stage search pipeline with valid/ready handshakes. It reports the two lowest-index matching entries and the total match count. Next-generation replacement for the fixed 10-bit × 16-entry TCAM. It sits between the packet-classifier key builder and the action lookup.

## Interface
- KEY_W, 10: key/mask width in bits
- DEPTH, 16: number of entries, ≥2
- AW, $clog2(DEPTH): derived, entry address width
- CW, $clog2(DEPTH+1): derived, match-count width

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- wr_en  in  1  write entry this cycle
- wr_addr  in  AW  entry index
- wr_key  in  KEY_W  stored key
- wr_mask  in  KEY_W  1 = don't-care bit
- wr_valid  in  1  new valid bit for the entry; 0 invalidates it
- srch_valid  in  1  search request
- srch_ready  out  1  search accepted when srch_valid && srch_ready
- srch_key  in  KEY_W  search key
- rslt_valid  out  1  result available
- rslt_ready  in  1  result consumed when rslt_valid && rslt_ready
- rslt_hit0 / rslt_addr0  out  1 / AW  lowest-index match
- rslt_hit1 / rslt_addr1  out  1 / AW  second-lowest-index match
- rslt_count  out  CW  number of matching entries

## Operation
- Entry i matches when valid[i] && (((srch_key ^ key[i]) & ~mask[i]) == 0). An all-ones mask matches every key.
- Writes are never stalled. They update key, mask and valid of wr_addr at the clock edge. wr_addr ≥ DEPTH is ignored.
- Stage 1: on accept, the DEPTH-bit match vector is computed from the table contents before the edge and registered with s1_v.
- Stage 2: priority encoder plus popcount on the stage-1 vector. Results are registered into the rslt_* outputs.
- Addresses on a miss:
  - rslt_hit0=0 ⇒ rslt_addr0=0.
  - rslt_hit1=0 ⇒ rslt_addr1=0.
- Results are in acceptance order; there is no reordering or dropping.

## Timing
- Reset (reset=0): all valid bits cleared, s1_v=0, every rslt_* output=0, srch_ready=1. Key/mask storage need not be reset.
- Pipeline control:
  - advance = !rslt_valid || rslt_ready, and srch_ready = advance.
  - The whole pipe moves only on advance; otherwise s1 and the outputs hold.
- Latency: a search accepted at edge N shows rslt_valid=1 after edge N+1. With no backpressure, throughput is one search per cycle.
- Write/search same cycle: the search sees the old entry. The write is visible to searches accepted from the next cycle on.
- A stalled search already holds its match vector, so later writes do not alter it.
- Backpressure: at most 2 searches in flight (s1 + output). With rslt_ready=0 and both stages full, srch_ready=0.
- Reset asserted mid-operation: in-flight searches are discarded and the table is invalidated immediately (asynchronous). Operation resumes on the first edge after deassertion.

## Structure
- Package tcam_pkg: default KEY_W/DEPTH constants and a match-vector typedef parameterised by DEPTH.
- Sub-module tcam_prio_enc: combinational. Input: DEPTH-bit vector. Outputs: hit0/addr0, hit1/addr1, count. Instantiated once in stage 2.
- Storage is flops (key, mask, valid arrays); there is no RAM macro.

## Test plan
- Reset then search 10'b0001001100 → two cycles later rslt_valid=1, hit0=0, hit1=0, count=0; srch_ready=1 throughout.
- Table load:
  - Writes: addr 4 = 0001001100; addr 1 = 0001000111; addr 6 = 0001000111; all mask 0, wr_valid=1.
  - Search 0001000111 → addr0=1, addr1=6, count=2.
  - Search 0001001100 → addr0=4, hit1=0, count=1.
- Ternary and invalidate:
  - Add addr 9 = 0001000000 with mask 0000001111.
  - Search 0001001100 → addr0=4, addr1=9, count=2.
  - Write addr 4 with wr_valid=0, repeat the search → addr0=9, hit1=0, count=1.
- Collision: write addr 0 = 1111111111 in the same cycle as search 1111111111 → miss. The same search one cycle later → hit0=1, addr0=0.
- Backpressure:
  - Hold rslt_ready=0 and offer 3 back-to-back searches → only 2 accepted, then srch_ready=0.
  - A write issued during the stall does not change the held results.
  - Release rslt_ready → results drain in order and the third search is accepted.
- Reset mid-flight: assert reset with 2 searches in flight → rslt_valid drops immediately. After release, a search for 0001000111 misses (table invalid).
